// File: rtl/ame_scale_arb.sv
// ame_scale_arb: shares one ame_num_scale unit among NUM_REQ requesters behind a credit-guarded 2-entry response FIFO.
// Define AME_SCALE_ARB_RR_EN for round-robin arbitration; left undefined, the lowest requester index wins.
module ame_scale_arb #(
  parameter int NUM_REQ        = 4,
  parameter int COMP_DATA_BITS = 64,
  parameter int ID_BITS        = $clog2(NUM_REQ)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic [NUM_REQ-1:0]                           req_valid_i,
  output logic [NUM_REQ-1:0]                           req_ready_o,
  input  logic [NUM_REQ-1:0][3:0][COMP_DATA_BITS-1:0]  req_data_i,
  output logic                                         scl_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0]               scl_data_o,
  input  logic                                         scl_done_i,
  input  logic [$clog2(COMP_DATA_BITS)-1:0]            scl_shift_i,
  input  logic [3:0][COMP_DATA_BITS-1:0]               scl_data_i,
  output logic                                         rsp_valid_o,
  input  logic                                         rsp_ready_i,
  output logic [ID_BITS-1:0]                           rsp_id_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0]            rsp_shift_o,
  output logic [3:0][COMP_DATA_BITS-1:0]               rsp_data_o
);

  localparam int SW = $clog2(COMP_DATA_BITS);
  typedef logic [3:0][COMP_DATA_BITS-1:0] tuple_t;

  logic               inflight_q, inflight_d;
  logic [ID_BITS-1:0] tag_q;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic               wr_ptr_q, rd_ptr_q;
  logic [ID_BITS-1:0] id_mem_q    [2];
  logic [SW-1:0]      shift_mem_q [2];
  tuple_t             data_mem_q  [2];
  logic               err_q, post_rst_q;

  logic               pop, push, can_issue, issue, gnt_found;
  logic [ID_BITS-1:0] gnt_id;
  logic [NUM_REQ-1:0] rot_valid;
  logic [2:0]         occ;

  assign rsp_valid_o = (fifo_cnt_q != 2'd0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign push        = scl_done_i & inflight_q;
  assign occ         = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign can_issue   = (occ - {2'b00, pop}) < 3'd2;

`ifdef AME_SCALE_ARB_RR_EN
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;

  // Rotate so bit 0 is the requester at rr_ptr; the search is then a plain priority scan.
  assign rot_valid = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
`else
  assign rot_valid = req_valid_i;
`endif

  always_comb begin
    int off;
    off       = 0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && rot_valid[i]) begin
        gnt_found = 1'b1;
        off       = i;
      end
    end
`ifdef AME_SCALE_ARB_RR_EN
    gnt_id = ID_BITS'((int'(rr_ptr_q) + off) % NUM_REQ);
`else
    gnt_id = ID_BITS'(off);
`endif
  end

  // Requests are refused while reset is held so the grant is quiet from the first instant.
  assign issue       = can_issue & gnt_found & rst_n_i;
  assign req_ready_o = issue ? (NUM_REQ'(1) << gnt_id) : '0;
  assign scl_init_o  = issue;
  assign scl_data_o  = req_data_i[gnt_id];

  assign inflight_d = issue | (inflight_q & ~push);
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

`ifdef AME_SCALE_ARB_RR_EN
  assign rr_ptr_d = issue ? ID_BITS'((int'(gnt_id) + 1) % NUM_REQ) : rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      err_q      <= 1'b0;
      post_rst_q <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        id_mem_q[k]    <= '0;
        shift_mem_q[k] <= '0;
        data_mem_q[k]  <= '0;
      end
    end else begin
      post_rst_q <= 1'b0;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (issue) tag_q <= gnt_id;
      if (push) begin
        id_mem_q[wr_ptr_q]    <= tag_q;
        shift_mem_q[wr_ptr_q] <= scl_shift_i;
        data_mem_q[wr_ptr_q]  <= scl_data_i;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      // A done left over from before reset may land in the first cycle; that one is not an error.
      if (scl_done_i && !inflight_q && !post_rst_q) err_q <= 1'b1;
    end
  end

  assign rsp_id_o    = id_mem_q[rd_ptr_q];
  assign rsp_shift_o = shift_mem_q[rd_ptr_q];
  assign rsp_data_o  = data_mem_q[rd_ptr_q];

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    push |-> (fifo_cnt_q != 2'd2));
  a_err_sticky: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    err_q |=> err_q);

endmodule
